uart_alu_interface: RTL and testbench
=====================================

Name: uart_alu_interface

Overview:
- Sits directly downstream of the UART receiver and upstream of the UART transmitter.
- Takes the receiver's byte stream and assembles the ALU operands A and B and the opcode.
- Drives the combinational ALU with those values, then hands the ALU result to the transmitter as one byte.
- Sequences the transaction with an FSM and waits for the transmitter before accepting the next frame.

Parameters:
- NB_DATA, 8: width of UART bytes, ALU operands and ALU result.
- NB_OP, 6: opcode width; taken from the low NB_OP bits of the third received byte.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  reset, asynchronous, active-high.
- i_rx_data  input  NB_DATA  received byte from the UART receiver; valid only while i_rx_valid=1.
- i_rx_valid  input  1  one-cycle pulse per received byte.
- i_alu_result  input  NB_DATA  combinational ALU output, computed from o_alu_a, o_alu_b and o_alu_op.
- i_tx_done  input  1  one-cycle pulse from the transmitter when the stop bit is finished.
- o_alu_a  output  NB_DATA  registered operand A.
- o_alu_b  output  NB_DATA  registered operand B.
- o_alu_op  output  NB_OP  registered opcode.
- o_tx_data  output  NB_DATA  byte to transmit; held stable from the o_tx_start cycle until i_tx_done.
- o_tx_start  output  1  one-cycle pulse requesting transmission.
- o_busy  output  1  high from opcode capture until i_tx_done is accepted.

Behaviour:
- Reset (asynchronous, active-high, any state): state=WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_start=0; o_busy=0.
- All registers update on the rising edge of i_clk.
- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, START_TX, WAIT_TX.
- WAIT_A: on i_rx_valid, o_alu_a <= i_rx_data and go to WAIT_B.
- WAIT_B: on i_rx_valid, o_alu_b <= i_rx_data and go to WAIT_OP.
- WAIT_OP: on i_rx_valid, o_alu_op <= i_rx_data[NB_OP-1:0] and o_busy <= 1; go to EXEC. Upper bits of that byte are discarded.
- EXEC: one settle cycle so the ALU sees the new operands. o_tx_data <= i_alu_result; go to START_TX.
- START_TX: o_tx_start=1 for exactly this one cycle; go to WAIT_TX.
- WAIT_TX: on i_tx_done, o_busy <= 0 and go to WAIT_A. o_tx_data is held.
- Latency: from the opcode-byte i_rx_valid edge, o_tx_start is high in the 3rd cycle after that edge (edges 1 and 2 are the EXEC and START_TX transitions).
- In the idle wait states (WAIT_A/B/OP), o_tx_start=0 and i_tx_done is ignored.
- Stored operands and opcode remain on o_alu_* after a transaction until overwritten by the next frame. The ALU output therefore stays valid for observation.
- Bytes arriving in EXEC, START_TX or WAIT_TX are dropped, with no partial capture. The next frame starts at WAIT_A after i_tx_done.
- If i_rx_valid and i_tx_done coincide in WAIT_TX, the done is accepted and the byte is dropped (the state was WAIT_TX on that edge).
- A held i_rx_valid (not a pulse) is outside the contract. Each high cycle counts as one byte.
- There is no timeout: a partial frame (e.g. only A received) waits indefinitely. Reset is the only recovery.
- Reset asserted mid-frame or during WAIT_TX returns to WAIT_A immediately, with o_tx_start forced low; any pending transmission is abandoned.
- There are no unreachable states. The default branch returns to WAIT_A.

Test Plan:
- Basic ADD: pulse rx bytes 0x05, 0x03, 0x20; the bench ALU model returns A+B. Required: o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20; o_tx_data=0x08; o_tx_start is a single pulse 3 cycles after the opcode edge; o_busy=1 until i_tx_done.
- Opcode masking / SUB: bytes 0xF0, 0x10, 0xE2 (low 6 bits = 0x22). Required: o_alu_op=0x22, o_tx_data=0xE0.
- Bytes during busy: after the opcode, pulse rx 0xAA twice in WAIT_TX, then i_tx_done. Required: no capture, o_alu_a unchanged. The next frame 0x01, 0x01, 0x20 yields o_tx_data=0x02.
- Coincident events: i_rx_valid(0x77) and i_tx_done in the same cycle in WAIT_TX. Required: return to WAIT_A with 0x77 dropped, o_busy=0.
- Reset mid-operation: assert i_reset asynchronously (not clock-aligned) after byte B, and separately in WAIT_TX. Required: all outputs 0 immediately; the next full frame processes correctly.
- Back-to-back frames: three consecutive frames with i_tx_done returned 10 cycles after each start. Required: exactly three o_tx_start pulses with the correct results.

Source files
------------

// File: rtl/uart_alu_interface.sv
// uart_alu_interface: collects operand A, operand B and opcode bytes from the
// UART receiver and presents them to a combinational ALU. It then registers the
// ALU result and hands it to the UART transmitter as a single byte. Bytes that
// arrive while a result is in flight are dropped. The next frame is not
// accepted until the transmitter reports done.
module uart_alu_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    WAIT_A   = 3'd0,
    WAIT_B   = 3'd1,
    WAIT_OP  = 3'd2,
    EXEC     = 3'd3,
    START_TX = 3'd4,
    WAIT_TX  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] alu_a_q, alu_a_d;
  logic [NB_DATA-1:0] alu_b_q, alu_b_d;
  logic [NB_OP-1:0]   alu_op_q, alu_op_d;
  logic [NB_DATA-1:0] tx_data_q, tx_data_d;
  logic               tx_start_q, tx_start_d;
  logic               busy_q, busy_d;

  // Next-state and datapath capture; every register holds its value unless its state acts on it.
  always_comb begin
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      WAIT_A: begin
        if (i_rx_valid) begin
          alu_a_d = i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (i_rx_valid) begin
          alu_b_d = i_rx_data;
          state_d = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (i_rx_valid) begin
          // Only the low opcode bits are meaningful; the rest of the byte is discarded.
          alu_op_d = i_rx_data[NB_OP-1:0];
          busy_d   = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // The operands have been stable on the ALU for a full cycle, so its result has settled.
        tx_data_d = i_alu_result;
        state_d   = START_TX;
      end
      START_TX: begin
        // The start flag is registered, so the pulse appears during the first WAIT_TX cycle.
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
      end
      WAIT_TX: begin
        // A byte that coincides with done is dropped because it was sampled in WAIT_TX.
        if (i_tx_done) begin
          busy_d  = 1'b0;
          state_d = WAIT_A;
        end
      end
      default: begin
        state_d = WAIT_A;
      end
    endcase
  end

  // State and output registers; reset abandons any frame or pending transmission at once.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed testbench for uart_alu_interface. Inputs are driven and outputs
// sampled on the falling clock edge. A small ALU model closes the loop.
module tb_uart_alu_interface;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] alu_result;
  logic       tx_done;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;

  int vectors;
  int miscompares;
  int start_pulses;

  uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_alu_result (alu_result),
    .i_tx_done    (tx_done),
    .o_alu_a      (alu_a),
    .o_alu_b      (alu_b),
    .o_alu_op     (alu_op),
    .o_tx_data    (tx_data),
    .o_tx_start   (tx_start),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: 0x20 add, 0x22 subtract, anything else xor.
  always_comb begin
    case (alu_op)
      6'h20:   alu_result = alu_a + alu_b;
      6'h22:   alu_result = alu_a - alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
  end

  // Count start pulses.
  always @(negedge clk) if (tx_start === 1'b1) start_pulses++;

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
  endtask

  // Send a three-byte frame and wait, with a bound, for the start pulse.
  // start_cyc is the number of falling edges after the opcode edge, or 0 on timeout.
  task automatic drive_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             output logic [7:0] seen_tx, output int start_cyc,
                             output logic seen_busy);
    int cyc;
    send_byte(a);
    send_byte(b);
    send_byte(op);
    cyc = 1;
    while (tx_start !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    seen_tx   = tx_data;
    seen_busy = busy;
    start_cyc = (tx_start === 1'b1) ? cyc : 0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    vectors++; if (alu_a !== 8'h00) begin miscompares++; $display("FAIL reset_a got=%h exp=00", alu_a); end
    vectors++; if (alu_b !== 8'h00) begin miscompares++; $display("FAIL reset_b got=%h exp=00", alu_b); end
    vectors++; if (alu_op !== 6'h00) begin miscompares++; $display("FAIL reset_op got=%h exp=00", alu_op); end
    vectors++; if (tx_data !== 8'h00) begin miscompares++; $display("FAIL reset_tx got=%h exp=00", tx_data); end
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL reset_start got=%b exp=0", tx_start); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset: outputs cleared");
  endtask

  task automatic test_basic_add();
    logic [7:0] tx;
    int         sc;
    logic       bz;
    drive_frame(8'h05, 8'h03, 8'h20, tx, sc, bz);
    vectors++; if (sc != 3) begin miscompares++; $display("FAIL add_latency got=%0d exp=3", sc); end
    vectors++; if (tx !== 8'h08) begin miscompares++; $display("FAIL add_tx got=%h exp=08", tx); end
    vectors++; if (bz !== 1'b1) begin miscompares++; $display("FAIL add_busy got=%b exp=1", bz); end
    vectors++; if (alu_a !== 8'h05 || alu_b !== 8'h03 || alu_op !== 6'h20) begin
      miscompares++; $display("FAIL add_operands got=%h/%h/%h exp=05/03/20", alu_a, alu_b, alu_op);
    end
    @(negedge clk);
    vectors++; if (tx_start !== 1'b0) begin miscompares++; $display("FAIL add_single_pulse got=%b exp=0", tx_start); end
    repeat (3) @(negedge clk);
    vectors++; if (busy !== 1'b1 || tx_data !== 8'h08) begin
      miscompares++; $display("FAIL add_hold got busy=%b tx=%h exp busy=1 tx=08", busy, tx_data);
    end
    pulse_done();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL add_done_busy got=%b exp=0", busy); end
    $display("basic_add: 05+03 -> %h start at cycle %0d", tx, sc);
  endtask

  task automatic test_opcode_mask();
    logic [7:0] tx;
    int         sc;
    logic       bz;
    drive_frame(8'hF0, 8'h10, 8'hE2, tx, sc, bz);
    vectors++; if (alu_op !== 6'h22) begin miscompares++; $display("FAIL mask_op got=%h exp=22", alu_op); end
    vectors++; if (tx !== 8'hE0 || sc != 3) begin
      miscompares++; $display("FAIL mask_tx got=%h cyc=%0d exp=E0 cyc=3", tx, sc);
    end
    pulse_done();
    $display("opcode_mask: op byte E2 -> op %h tx %h", alu_op, tx);
  endtask

  task automatic test_busy_drop();
    logic [7:0] tx;
    int         sc;
    logic       bz;
    drive_frame(8'h11, 8'h22, 8'h20, tx, sc, bz);
    vectors++; if (tx !== 8'h33) begin miscompares++; $display("FAIL drop_first_tx got=%h exp=33", tx); end
    send_byte(8'hAA);
    send_byte(8'hAA);
    vectors++; if (alu_a !== 8'h11 || alu_b !== 8'h22 || alu_op !== 6'h20) begin
      miscompares++; $display("FAIL drop_no_capture got=%h/%h/%h exp=11/22/20", alu_a, alu_b, alu_op);
    end
    pulse_done();
    drive_frame(8'h01, 8'h01, 8'h20, tx, sc, bz);
    vectors++; if (tx !== 8'h02 || sc != 3 || alu_a !== 8'h01) begin
      miscompares++; $display("FAIL drop_next_frame got tx=%h cyc=%0d a=%h exp tx=02 cyc=3 a=01", tx, sc, alu_a);
    end
    pulse_done();
    $display("busy_drop: AA bytes ignored, next frame tx %h", tx);
  endtask

  task automatic test_coincident();
    logic [7:0] tx;
    int         sc;
    logic       bz;
    drive_frame(8'h40, 8'h02, 8'h20, tx, sc, bz);
    vectors++; if (tx !== 8'h42) begin miscompares++; $display("FAIL coin_tx got=%h exp=42", tx); end
    @(negedge clk);
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    tx_done  = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    tx_done  = 1'b0;
    vectors++; if (busy !== 1'b0 || alu_a !== 8'h40) begin
      miscompares++; $display("FAIL coin_done got busy=%b a=%h exp busy=0 a=40", busy, alu_a);
    end
    send_byte(8'h09);
    vectors++; if (alu_a !== 8'h09) begin miscompares++; $display("FAIL coin_next_a got=%h exp=09", alu_a); end
    send_byte(8'h01);
    send_byte(8'h20);
    repeat (3) @(negedge clk);
    vectors++; if (tx_data !== 8'h0A) begin miscompares++; $display("FAIL coin_next_tx got=%h exp=0A", tx_data); end
    pulse_done();
    $display("coincident: 77 dropped, following frame tx %h", tx_data);
  endtask

  task automatic test_reset_mid();
    logic [7:0] tx;
    int         sc;
    logic       bz;
    send_byte(8'h33);
    send_byte(8'h44);
    #2 rst = 1'b1;
    #1;
    vectors++; if (alu_a !== 8'h00 || alu_b !== 8'h00 || busy !== 1'b0 || tx_start !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_frame got a=%h b=%h busy=%b start=%b exp all 0", alu_a, alu_b, busy, tx_start);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_frame(8'h06, 8'h07, 8'h20, tx, sc, bz);
    vectors++; if (tx !== 8'h0D || sc != 3) begin
      miscompares++; $display("FAIL rstmid_recover got tx=%h cyc=%0d exp tx=0D cyc=3", tx, sc);
    end
    pulse_done();
    drive_frame(8'h08, 8'h08, 8'h20, tx, sc, bz);
    #3 rst = 1'b1;
    #1;
    vectors++; if (tx_start !== 1'b0 || busy !== 1'b0 || tx_data !== 8'h00 || alu_op !== 6'h00) begin
      miscompares++; $display("FAIL rstmid_waittx got start=%b busy=%b tx=%h op=%h exp 0/0/00/00", tx_start, busy, tx_data, alu_op);
    end
    @(negedge clk);
    rst = 1'b0;
    drive_frame(8'h02, 8'h03, 8'h22, tx, sc, bz);
    vectors++; if (tx !== 8'hFF || sc != 3) begin
      miscompares++; $display("FAIL rstmid_recover2 got tx=%h cyc=%0d exp tx=FF cyc=3", tx, sc);
    end
    pulse_done();
    $display("reset_mid: recovered, last tx %h", tx);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a_v  [3] = '{8'h10, 8'h50, 8'h0F};
    logic [7:0] b_v  [3] = '{8'h20, 8'h30, 8'hF0};
    logic [7:0] op_v [3] = '{8'h20, 8'h22, 8'h24};
    logic [7:0] exp_v[3] = '{8'h30, 8'h20, 8'hFF};
    logic [7:0] tx;
    int         sc;
    logic       bz;
    start_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      drive_frame(a_v[i], b_v[i], op_v[i], tx, sc, bz);
      vectors++; if (tx !== exp_v[i] || sc != 3) begin
        miscompares++; $display("FAIL b2b_frame%0d got tx=%h cyc=%0d exp tx=%h cyc=3", i, tx, sc, exp_v[i]);
      end
      repeat (9) @(negedge clk);
      pulse_done();
      $display("back_to_back: frame %0d tx %h", i, tx);
    end
    repeat (2) @(negedge clk);
    vectors++; if (start_pulses != 3) begin miscompares++; $display("FAIL b2b_pulses got=%0d exp=3", start_pulses); end
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    start_pulses = 0;
    rst          = 1'b0;
    rx_data      = 8'h00;
    rx_valid     = 1'b0;
    tx_done      = 1'b0;
    test_reset();
    test_basic_add();
    test_opcode_mask();
    test_busy_drop();
    test_coincident();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
